// File: rtl/mem_block_mover.sv
// mem_block_mover
//
// Bus-initiator engine for a single-port byte RAM with a registered read.
// It either copies a block of bytes from one RAM region to another, or fills
// a region with a constant byte. While busy it owns the RAM port.
//
// Ports
//   clk          system clock, rising edge
//   RST          synchronous, active-high reset
//   start        command strobe, sampled only in IDLE
//   mode         0 = copy, 1 = fill (latched on start)
//   src_addr     copy source base (latched on start, ignored in fill)
//   dst_addr     destination base (latched on start)
//   length       byte count (latched on start)
//   fill_value   fill byte (latched on start)
//   abort        ends an active transfer after the current access
//   busy         high while accessing RAM (READ/WRITE/FILL)
//   done         one-cycle pulse at the end of every command
//   error        range error on the last command
//   bytes_done   RAM writes completed for the current/last command
//   mem_address  RAM address
//   mem_data     RAM write data
//   mem_read     RAM read strobe
//   mem_write    RAM write strobe
//   mem_dataout  RAM read data, valid the cycle after a mem_read cycle
module mem_block_mover #(
  parameter int MEM_DEPTH = 32768
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  input  logic [7:0]  fill_value,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] bytes_done,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_dataout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  state_t      state;
  logic        mode_q;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [15:0] len_q;
  logic [7:0]  fill_q;
  logic [15:0] idx;
  logic [15:0] bytes_q;
  logic        error_q;

  // Region end addresses are formed in 17 bits so a region that runs past
  // 0xFFFF cannot wrap around and pass the range check.
  logic [16:0] dst_end;
  logic [16:0] src_end;
  logic        range_err;
  logic        last;

  assign dst_end   = {1'b0, dst_addr} + {1'b0, length};
  assign src_end   = {1'b0, src_addr} + {1'b0, length};
  assign range_err = (dst_end > DEPTH) || (!mode && (src_end > DEPTH));
  assign last      = ({1'b0, idx} + 17'd1) == {1'b0, len_q};

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      idx     <= '0;
      bytes_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start takes priority over abort here; abort is simply not looked at
          if (start) begin
            mode_q  <= mode;
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= length;
            fill_q  <= fill_value;
            idx     <= '0;
            bytes_q <= '0;
            error_q <= range_err;
            if (range_err || (length == 16'd0)) state <= S_DONE;
            else if (mode)                      state <= S_FILL;
            else                                state <= S_READ;
          end
        end
        S_READ: begin
          state <= abort ? S_DONE : S_WRITE;
        end
        S_WRITE, S_FILL: begin
          // The write issued this cycle always lands, even when aborting.
          bytes_q <= bytes_q + 16'd1;
          idx     <= idx + 16'd1;
          if (abort || last)       state <= S_DONE;
          else if (state == S_FILL) state <= S_FILL;
          else                      state <= S_READ;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode only the registered state and latched command, so
  // start/abort can never glitch a strobe. In WRITE the RAM's registered read
  // data from the preceding READ is forwarded directly, so no wait state.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state)
      S_READ: begin
        busy        = 1'b1;
        mem_read    = 1'b1;
        mem_address = src_q + idx;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_write   = 1'b1;
        mem_address = dst_q + idx;
        mem_data    = mem_dataout;
      end
      S_FILL: begin
        busy        = 1'b1;
        mem_write   = 1'b1;
        mem_address = dst_q + idx;
        mem_data    = fill_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign error      = error_q;
  assign bytes_done = bytes_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Self-checking bench for mem_block_mover.
// A behavioural RAM with registered read is attached to the bus port. A
// reference image of the RAM is updated from the command semantics (ascending
// byte copy / fill) and the expected bus access sequence is derived from the
// command, the length and the abort/reset point.
module tb_mem_block_mover;

  localparam int DEPTH = 32768;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [7:0]  fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] bytes_done;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_dataout;

  logic [7:0]  ram     [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  ram_q;
  logic        ram_init;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_block_mover #(.MEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .RST         (RST),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .fill_value  (fill_value),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .bytes_done  (bytes_done),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_dataout (mem_dataout)
  );

  function automatic logic [7:0] init_pattern(input int i);
    return 8'((i * 37) ^ (i >> 7) ^ 8'h5C);
  endfunction

  // Behavioural RAM: write on a write strobe, registered read on a read strobe.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_pattern(i);
      ram_q <= 8'h00;
    end else begin
      if (mem_write) ram[mem_address[14:0]] <= mem_data;
      if (mem_read)  ram_q <= ram[mem_address[14:0]];
    end
  end
  assign mem_dataout = ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ram_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Idle-like bus state: no strobes, zero address/data, not busy.
  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " rd"},   32'(mem_read), 32'd0);
    check({tag, " wr"},   32'(mem_write), 32'd0);
    check({tag, " addr"}, 32'(mem_address), 32'd0);
    check({tag, " data"}, 32'(mem_data), 32'd0);
  endtask

  // Issue one command at the current negedge and follow it cycle by cycle.
  // abort_at / rst_at: index of the access cycle during which abort / RST is
  // raised (-1 = never). noise: scramble command inputs and pulse start while
  // busy, and raise abort together with start in IDLE.
  task automatic run_cmd(input string name, input logic m, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] l,
                         input logic [7:0] fv, input int abort_at,
                         input int rst_at, input bit noise);
    logic [16:0] se, de;
    bit          err, rd;
    int          n, nwr, i;
    logic [15:0] ea;
    logic [7:0]  ed;
    string       t;
    de  = {1'b0, d} + {1'b0, l};
    se  = {1'b0, s} + {1'b0, l};
    err = (de > 17'(DEPTH)) || (!m && (se > 17'(DEPTH)));
    n   = (err || l == 16'd0) ? 0 : (m ? int'(l) : 2 * int'(l));
    if (abort_at >= 0 && abort_at < n) n = abort_at + 1;
    nwr = 0;

    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = fv;
    start = 1'b1;
    abort = noise ? 1'($urandom) : 1'b0;

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rd = !m && (k % 2 == 0);
      i  = m ? k : k / 2;
      ea = rd ? s + 16'(i) : d + 16'(i);
      ed = m ? fv : ref_mem[15'(s + 16'(i))];
      t  = $sformatf("%s k%0d", name, k);
      check({t, " busy"}, 32'(busy), 32'd1);
      check({t, " done"}, 32'(done), 32'd0);
      check({t, " rd"},   32'(mem_read), 32'(rd));
      check({t, " wr"},   32'(mem_write), 32'(!rd));
      check({t, " addr"}, 32'(mem_address), 32'(ea));
      if (!rd) begin
        check({t, " data"}, 32'(mem_data), 32'(ed));
        ref_mem[15'(ea)] = ed;
        nwr++;
      end
      start = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
        length = 16'($urandom); fill_value = 8'($urandom);
      end
      abort = (k == abort_at);
      if (k == rst_at) begin
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0; start = 1'b0; abort = 1'b0;
        check_quiet({name, " rst"}, 1'b0);
        check({name, " rst bytes"}, 32'(bytes_done), 32'd0);
        check({name, " rst err"},   32'(error), 32'd0);
        ram_compare({name, " rst ram"});
        return;
      end
    end

    @(negedge clk);
    check_quiet({name, " done"}, 1'b1);
    check({name, " bytes"}, 32'(bytes_done), 32'(nwr));
    check({name, " err"},   32'(error), 32'(err));
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_quiet({name, " idle"}, 1'b0);
    check({name, " hold bytes"}, 32'(bytes_done), 32'(nwr));
    check({name, " hold err"},   32'(error), 32'(err));
    ram_compare({name, " ram"});
  endtask

  initial begin
    logic        m;
    logic [15:0] s, d, l;
    int          ab;

    RST = 1'b1; ram_init = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pattern(i);
    repeat (3) @(negedge clk);
    check_quiet("reset", 1'b0);
    check("reset err",   32'(error), 32'd0);
    check("reset bytes", 32'(bytes_done), 32'd0);
    RST = 1'b0; ram_init = 1'b0;
    @(negedge clk);

    // Preload source bytes through single-byte fills.
    run_cmd("pre0", 1'b1, 16'h0, 16'h0010, 16'd1, 8'hA1, -1, -1, 1'b0);
    run_cmd("pre1", 1'b1, 16'h0, 16'h0011, 16'd1, 8'hB2, -1, -1, 1'b0);
    run_cmd("pre2", 1'b1, 16'h0, 16'h0012, 16'd1, 8'hC3, -1, -1, 1'b0);
    run_cmd("pre3", 1'b1, 16'h0, 16'h0013, 16'd1, 8'hD4, -1, -1, 1'b0);
    run_cmd("copy4", 1'b0, 16'h0010, 16'h0100, 16'd4, 8'h00, -1, -1, 1'b0);
    check("copy4 b0", 32'(ram[16'h100]), 32'hA1);
    check("copy4 b3", 32'(ram[16'h103]), 32'hD4);

    run_cmd("fill_top", 1'b1, 16'h0, 16'h7FFC, 16'd4, 8'h5A, -1, -1, 1'b0);
    check("fill_top last", 32'(ram[16'h7FFF]), 32'h5A);
    run_cmd("fill_over", 1'b1, 16'h0, 16'h7FFC, 16'd5, 8'h33, -1, -1, 1'b0);
    run_cmd("copy_src_over", 1'b0, 16'h7FF0, 16'h0000, 16'h0020, 8'h00, -1, -1, 1'b0);
    run_cmd("copy_len0", 1'b0, 16'h0040, 16'h0080, 16'd0, 8'h00, -1, -1, 1'b0);

    // Abort during the 3rd WRITE (access index 5).
    run_cmd("abort", 1'b0, 16'h0200, 16'h0300, 16'd10, 8'h00, 5, -1, 1'b0);

    run_cmd("pre_ov", 1'b1, 16'h0, 16'h0020, 16'd1, 8'h77, -1, -1, 1'b0);
    run_cmd("overlap", 1'b0, 16'h0020, 16'h0021, 16'd3, 8'h00, -1, -1, 1'b0);
    check("overlap end", 32'(ram[16'h23]), 32'h77);

    // Reset during the 2nd fill write's edge: two bytes land.
    run_cmd("rst_fill", 1'b1, 16'h0, 16'h0400, 16'd8, 8'hE7, -1, 1, 1'b0);

    // start pulses and input changes while busy must not disturb the transfer.
    run_cmd("noisy_copy", 1'b0, 16'h0500, 16'h0600, 16'd6, 8'h00, -1, -1, 1'b1);
    run_cmd("noisy_fill", 1'b1, 16'h0, 16'h0700, 16'd5, 8'h9C, -1, -1, 1'b1);

    repeat (150) begin
      m = 1'($urandom);
      l = 16'($urandom_range(0, 12));
      s = 16'($urandom_range(0, DEPTH - 1));
      d = 16'($urandom_range(0, DEPTH - 1));
      if ($urandom % 8 == 0) d = 16'(DEPTH - $urandom_range(0, 10));
      if ($urandom % 10 == 0) s = 16'($urandom);
      ab = ($urandom % 4 == 0) ? $urandom_range(0, 24) : -1;
      run_cmd("rnd", m, s, d, l, 8'($urandom), ab, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Bus-initiator engine that drives the single-port byte RAM (16-bit address, 8-bit data, registered read) on behalf of the I/O module. Given a source, destination and length, it copies a byte block from one RAM region to another, or fills a region with a constant. It sits between the I/O control logic and the RAM's `address`/`data`/`read_signal`/`write_signal`/`dataout` port. It owns that port exclusively while busy.

## Interface
- `MEM_DEPTH`, 32768: number of addressable RAM bytes; valid addresses are 0..MEM_DEPTH-1.
- `clk`  in  1  system clock; everything is updated on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle command strobe, sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched on start.
- `src_addr`  in  16  copy source base; latched on start; ignored in fill.
- `dst_addr`  in  16  destination base; latched on start.
- `length`  in  16  byte count; latched on start.
- `fill_value`  in  8  fill byte; latched on start.
- `abort`  in  1  stops an active transfer.
- `busy`  out  1  high in READ/WRITE/FILL.
- `done`  out  1  one-cycle pulse at transfer end (normal, aborted or error).
- `error`  out  1  range error on the last command; held until the next accepted start or RST.
- `bytes_done`  out  16  number of RAM writes completed for the current/last command.
- `mem_address`  out  16  RAM address.
- `mem_data`  out  8  RAM write data.
- `mem_read`  out  1  RAM read strobe.
- `mem_write`  out  1  RAM write strobe.
- `mem_dataout`  in  8  RAM read data; valid the cycle after a `mem_read` cycle.

## Operation
- States: IDLE, READ, WRITE, FILL, DONE.
- Memory strobes and `busy` are Moore outputs of the state, so they are never glitched by `abort` or `start`.
- `mem_read` and `mem_write` are never high together. Both are 0 in IDLE and DONE.
- IDLE: on `start`=1 the engine latches all command inputs, clears `bytes_done` and `error`, and sets index i=0.
  - Range check uses 17-bit sums.
  - Error if `dst_addr+length > MEM_DEPTH`.
  - In copy mode, also error if `src_addr+length > MEM_DEPTH`.
  - On error: go to DONE with `error`=1 and no RAM access.
  - If `length`=0 (and no error): go to DONE with no RAM access.
  - Otherwise: copy goes to READ, fill goes to FILL.
- READ: `mem_read`=1, `mem_address`=src+i. Next state is WRITE.
- WRITE: `mem_write`=1, `mem_address`=dst+i, `mem_data`=`mem_dataout`.
  - At the edge, `bytes_done`++ and i++.
  - Next state is DONE if i+1 = length; otherwise READ.
- FILL: `mem_write`=1, `mem_address`=dst+i, `mem_data`=latched `fill_value`.
  - At the edge, `bytes_done`++ and i++.
  - Next state is DONE if i+1 = length; otherwise FILL.
- `abort`=1 sampled in READ, WRITE or FILL: the current cycle's access still completes (and a WRITE/FILL still counts). Next state is DONE.
- DONE: `done`=1 for one cycle, then IDLE. `bytes_done` and `error` hold.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `start` wins, `abort` is ignored.
- Overlapping copy regions are handled strictly in ascending address order, with no hazard correction. For example, dst = src+1 replicates byte src across the region.
- `mem_data` shows 0 when not in WRITE or FILL. `mem_address` shows 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `error`=0, `bytes_done`=0; `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_data`=0.
- `RST` mid-transfer takes effect at that edge. No further strobes are issued, and bytes already written stay in RAM.
- `start` is accepted at edge E0. The first access cycle is E0→E1.
- Copy of L bytes: 2L access cycles, then `done` in cycle 2L+1 after E0, then IDLE.
- Fill of L bytes: L access cycles, then `done` in cycle L+1.
- Zero-length or error command: `done` in the first cycle after E0.
- Back-to-back: the earliest next `start` is sampled in the IDLE cycle after DONE.
- Read data: the RAM captures at the end of READ, and WRITE uses `mem_dataout` in the following cycle. The engine therefore adds no extra wait state.

## Test plan
- Copy src=0x0010, dst=0x0100, L=4, with RAM[0x10..0x13]=A1,B2,C3,D4 -> strobes alternate R/W over 8 cycles; RAM[0x100..0x103]=A1,B2,C3,D4; `done` pulse in cycle 9; `bytes_done`=4; `error`=0.
- Fill dst=0x7FFC, L=4, value 0x5A -> RAM[0x7FFC..0x7FFF]=5A; `done` in cycle 5. Repeat with L=5 -> `error`=1, `done` in cycle 1, no `mem_write`.
- L=0 copy -> no strobes; `done` in cycle 1; `bytes_done`=0; `error`=0.
- Copy L=10 with `abort` asserted during the 3rd WRITE -> exactly 3 bytes written; `bytes_done`=3; `done` next cycle; destination bytes 3..9 unchanged.
- Overlap copy src=0x20, dst=0x21, L=3, with RAM[0x20]=0x77 -> RAM[0x21..0x23]=77.
- `RST` during FILL after 2 writes -> all outputs at reset values the next cycle; 2 bytes filled. `start` pulsed while busy is ignored (no restart, no latch change).
